// File: rtl/bcd_field_counter_pkg.sv
// bcd_field_counter_pkg: shared FSM encoding and BCD digit constants
package bcd_field_counter_pkg;
  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_e;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with load, enable, up/down and a top value
module bcd_digit
  import bcd_field_counter_pkg::*;
#(
  parameter logic [BCD_W-1:0] TOP = BCD_NINE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             down_i,
  output logic [BCD_W-1:0] q_o,
  output logic             tc_o,
  output logic             tz_o
);
  logic [BCD_W-1:0] q_q, q_d;
  assign tc_o = q_q == TOP;
  assign tz_o = q_q == BCD_ZERO;
  assign q_o  = q_q;
  // load wins over stepping; stepping wraps at TOP/zero inside the digit
  always_comb
    q_d = load_i ? load_val_i :
          !en_i  ? q_q :
          down_i ? (tz_o ? TOP : q_q - 4'd1) :
                   (tc_o ? BCD_ZERO : q_q + 4'd1);
  // digit register
  always_ff @(posedge clk)
    q_q <= reset ? BCD_ZERO : q_d;
endmodule

// File: rtl/bcd_field_counter.sv
// bcd_field_counter: two-digit BCD up/down field counter with run/stop FSM and validated load
module bcd_field_counter
  import bcd_field_counter_pkg::*;
#(
  parameter int MAX_VALUE    = 59,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [3:0] init_tens,
  input  logic [3:0] init_ones,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       down,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       cout,
  output logic       bout,
  output logic       running,
  output logic       load_err
);
  localparam logic [BCD_W-1:0] MAX_T    = 4'(MAX_VALUE / 10);
  localparam logic [BCD_W-1:0] MAX_O    = 4'(MAX_VALUE % 10);
  localparam logic [BCD_W-1:0] ONES_TOP = MAX_VALUE < 10 ? MAX_O : BCD_NINE;
  state_e state_q, state_d;
  logic cout_q, cout_d, bout_q, bout_d, lerr_q, lerr_d;
  logic ones_tc, ones_tz, tens_tc, tens_tz;
  logic legal, at_max, at_zero, adv, wrap_up, wrap_dn, ld;
  logic [BCD_W-1:0] ld_t, ld_o;
  assign legal   = init_tens <= BCD_NINE && init_ones <= BCD_NINE &&
                   int'(init_tens) * 10 + int'(init_ones) <= MAX_VALUE;
  assign at_max  = tens_tc && ones == MAX_O;
  assign at_zero = tens_tz && ones_tz;
  assign adv     = state_q == RUNNING && tick && !set && !stop && !start_resume;
  assign wrap_up = adv && !down && at_max;
  assign wrap_dn = adv && down && at_zero;
  assign ld      = set || wrap_up || wrap_dn;
  assign ld_t    = set ? (legal ? init_tens : MAX_T) : wrap_dn ? MAX_T : BCD_ZERO;
  assign ld_o    = set ? (legal ? init_ones : MAX_O) : wrap_dn ? MAX_O : BCD_ZERO;
  bcd_digit #(.TOP(ONES_TOP)) u_ones (
    .clk(clk), .reset(reset), .load_i(ld), .load_val_i(ld_o), .en_i(adv),
    .down_i(down), .q_o(ones), .tc_o(ones_tc), .tz_o(ones_tz)
  );
  bcd_digit #(.TOP(MAX_T)) u_tens (
    .clk(clk), .reset(reset), .load_i(ld), .load_val_i(ld_t),
    .en_i(adv && (down ? ones_tz : ones_tc)),
    .down_i(down), .q_o(tens), .tc_o(tens_tc), .tz_o(tens_tz)
  );
  // run/stop transitions and pulse flags; a set freezes the FSM for that cycle
  always_comb begin
    state_d = set ? state_q : stop ? STOPPED : start_resume ? RUNNING : state_q;
    cout_d  = wrap_up;
    bout_d  = wrap_dn;
    lerr_d  = set && !legal;
  end
  // FSM state and pulse registers
  always_ff @(posedge clk) begin
    state_q <= reset ? (RUN_ON_RESET ? RUNNING : STOPPED) : state_d;
    cout_q  <= !reset && cout_d;
    bout_q  <= !reset && bout_d;
    lerr_q  <= !reset && lerr_d;
  end
  assign running  = state_q == RUNNING;
  assign cout     = cout_q;
  assign bout     = bout_q;
  assign load_err = lerr_q;
endmodule

// File: tb/tb_bcd_field_counter.sv
// tb_bcd_field_counter: directed and random checks of four counter instances against an integer model
module tb_bcd_field_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, set, start_resume, stop, down, tick;
  logic [3:0] init_tens, init_ones;
  logic [3:0] tens_w[4], ones_w[4];
  logic cout_w[4], bout_w[4], run_w[4], lerr_w[4];
  int maxv[4] = '{59, 23, 7, 59};
  bit ror[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  int val[4];
  bit run[4], co[4], bo[4], le[4];
  int checks = 0, errors = 0;
  bcd_field_counter #(.MAX_VALUE(59), .RUN_ON_RESET(1'b0)) u_sec (
    .clk(clk), .reset(reset), .set(set), .init_tens(init_tens), .init_ones(init_ones),
    .start_resume(start_resume), .stop(stop), .down(down), .tick(tick),
    .tens(tens_w[0]), .ones(ones_w[0]), .cout(cout_w[0]), .bout(bout_w[0]),
    .running(run_w[0]), .load_err(lerr_w[0]));
  bcd_field_counter #(.MAX_VALUE(23), .RUN_ON_RESET(1'b1)) u_hr (
    .clk(clk), .reset(reset), .set(set), .init_tens(init_tens), .init_ones(init_ones),
    .start_resume(start_resume), .stop(stop), .down(down), .tick(tick),
    .tens(tens_w[1]), .ones(ones_w[1]), .cout(cout_w[1]), .bout(bout_w[1]),
    .running(run_w[1]), .load_err(lerr_w[1]));
  bcd_field_counter #(.MAX_VALUE(7), .RUN_ON_RESET(1'b0)) u_small (
    .clk(clk), .reset(reset), .set(set), .init_tens(init_tens), .init_ones(init_ones),
    .start_resume(start_resume), .stop(stop), .down(down), .tick(tick),
    .tens(tens_w[2]), .ones(ones_w[2]), .cout(cout_w[2]), .bout(bout_w[2]),
    .running(run_w[2]), .load_err(lerr_w[2]));
  bcd_field_counter #(.MAX_VALUE(59), .RUN_ON_RESET(1'b0)) u_min (
    .clk(clk), .reset(reset), .set(set), .init_tens(init_tens), .init_ones(init_ones),
    .start_resume(start_resume), .stop(stop), .down(down), .tick(cout_w[0]),
    .tens(tens_w[3]), .ones(ones_w[3]), .cout(cout_w[3]), .bout(bout_w[3]),
    .running(run_w[3]), .load_err(lerr_w[3]));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int i, input bit r, s, sr, sp, dn, tk, input int it, io);
    if (r) begin
      val[i] = 0; run[i] = ror[i]; co[i] = 0; bo[i] = 0; le[i] = 0;
    end else begin
      co[i] = 0; bo[i] = 0; le[i] = 0;
      if (s) begin
        if (it > 9 || io > 9 || it * 10 + io > maxv[i]) begin
          val[i] = maxv[i]; le[i] = 1;
        end else val[i] = it * 10 + io;
      end else if (sp) run[i] = 0;
      else if (sr) run[i] = 1;
      else if (run[i] && tk) begin
        if (!dn) begin
          if (val[i] == maxv[i]) begin val[i] = 0; co[i] = 1; end
          else val[i] = val[i] + 1;
        end else begin
          if (val[i] == 0) begin val[i] = maxv[i]; bo[i] = 1; end
          else val[i] = val[i] - 1;
        end
      end
    end
  endtask
  task automatic cyc(input bit r, s, sr, sp, dn, tk, input logic [3:0] it, io);
    bit c0;
    reset = r; set = s; start_resume = sr; stop = sp; down = dn; tick = tk;
    init_tens = it; init_ones = io;
    @(posedge clk);
    c0 = co[0];
    step(3, r, s, sr, sp, dn, c0, int'(it), int'(io));
    for (int i = 0; i < 3; i++) step(i, r, s, sr, sp, dn, tk, int'(it), int'(io));
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tens%0d", i), 8'(tens_w[i]), 8'(val[i] / 10));
      chk($sformatf("ones%0d", i), 8'(ones_w[i]), 8'(val[i] % 10));
      chk($sformatf("cout%0d", i), 8'(cout_w[i]), 8'(co[i]));
      chk($sformatf("bout%0d", i), 8'(bout_w[i]), 8'(bo[i]));
      chk($sformatf("run%0d", i), 8'(run_w[i]), 8'(run[i]));
      chk($sformatf("lerr%0d", i), 8'(lerr_w[i]), 8'(le[i]));
    end
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    chk("rst_sec", {tens_w[0], ones_w[0]}, 8'h00);
    chk("rst_hr_run", 8'(run_w[1]), 8'd1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 59; n++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("up59", {tens_w[0], ones_w[0]}, 8'h59);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("wrap00", {tens_w[0], ones_w[0], 7'd0, cout_w[0]}, {8'h00, 8'h01});
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("cout_once", 8'(cout_w[0]), 8'd0);
    cyc(0, 1, 0, 0, 0, 0, 3, 7);
    cyc(0, 0, 0, 1, 0, 1, 0, 0);
    chk("stop_hold", {tens_w[0], ones_w[0]}, 8'h37);
    chk("stop_run", 8'(run_w[0]), 8'd0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("resume38", {tens_w[0], ones_w[0]}, 8'h38);
    cyc(0, 1, 0, 0, 0, 0, 7, 2);
    chk("set72", {tens_w[0], ones_w[0], 7'd0, lerr_w[0]}, {8'h59, 8'h01});
    cyc(0, 1, 0, 0, 0, 0, 3, 4'hA);
    chk("set3A", {tens_w[0], ones_w[0], 7'd0, lerr_w[0]}, {8'h59, 8'h01});
    cyc(0, 1, 0, 0, 0, 0, 4, 5);
    chk("set45", {tens_w[0], ones_w[0], 7'd0, lerr_w[0]}, {8'h45, 8'h00});
    cyc(0, 1, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("hr_bwrap", {tens_w[1], ones_w[1], 7'd0, bout_w[1]}, {8'h23, 8'h01});
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("hr22", {tens_w[1], ones_w[1]}, 8'h22);
    cyc(0, 1, 0, 0, 0, 0, 5, 8);
    cyc(1, 1, 0, 0, 0, 1, 5, 8);
    chk("rst_mid", {tens_w[0], ones_w[0], 5'd0, cout_w[0], bout_w[0], lerr_w[0]}, 16'h0000);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 5, 9);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("chain_sec", {tens_w[0], ones_w[0], 3'd0, cout_w[0], 3'd0, cout_w[3]}, {8'h00, 8'h10});
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("chain_min", {tens_w[3], ones_w[3], 3'd0, cout_w[0], 3'd0, cout_w[3]}, {8'h00, 8'h01});
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
          $urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
          4'($urandom_range(15)), 4'($urandom_range(15)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_field_counter.md
BCD_FIELD_COUNTER -- requirements
Module: bcd_field_counter

Interface
REQ-001 Parameter MAX_VALUE, default 59, is the highest count value; the legal range is 1..99 (59 for seconds/minutes, 23 for hours, 99 for centiseconds).
REQ-002 Parameter RUN_ON_RESET, default 0, is the run state after reset: 1 = RUNNING, 0 = STOPPED.
REQ-003 Port clk, input, 1 bit, is the single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-005 Port set, input, 1 bit, loads init_tens/init_ones on the next edge.
REQ-006 Port init_tens, input, 4 bits, is the BCD tens digit to load.
REQ-007 Port init_ones, input, 4 bits, is the BCD ones digit to load.
REQ-008 Port start_resume, input, 1 bit, is a level; high for one cycle enters RUNNING.
REQ-009 Port stop, input, 1 bit, is a level; high for one cycle enters STOPPED.
REQ-010 Port down, input, 1 bit, selects the count direction: 0 = up, 1 = down.
REQ-011 Port tick, input, 1 bit, is the count-enable strobe (1 Hz pulse, or the cout/bout of a lower field).
REQ-012 Port tens, output, 4 bits, is the registered BCD tens digit.
REQ-013 Port ones, output, 4 bits, is the registered BCD ones digit.
REQ-014 Port cout, output, 1 bit, is a one-cycle pulse on an up-wrap from MAX_VALUE to 00.
REQ-015 Port bout, output, 1 bit, is a one-cycle pulse on a down-wrap from 00 to MAX_VALUE.
REQ-016 Port running, output, 1 bit, is high in the RUNNING state.
REQ-017 Port load_err, output, 1 bit, is a one-cycle pulse when a set carries an illegal value.

Function
REQ-018 The block SHALL implement a two-state FSM: STOPPED and RUNNING.
REQ-019 In STOPPED, start_resume=1 and stop=0 SHALL move the FSM to RUNNING on the next edge.
REQ-020 In RUNNING, stop=1 SHALL move the FSM to STOPPED on the next edge, and stop SHALL win when start_resume=1 in the same cycle.
REQ-021 The count SHALL advance only when running=1 and tick=1; each qualifying cycle moves the count by exactly one step.
REQ-022 Counting up SHALL follow ones 0..9 then wrap to 0 with tens+1; from the value equal to MAX_VALUE the count SHALL go to 00 and cout SHALL assert.
REQ-023 Counting down SHALL follow ones 9..0 then borrow from tens; from 00 the count SHALL go to MAX_VALUE and bout SHALL assert.
REQ-024 tens, ones, cout and bout SHALL all be registered: a qualifying tick sampled at edge n updates the digits after edge n, and cout/bout are high for exactly the cycle after edge n.
REQ-025 set=1 SHALL load init_tens/init_ones on the next edge regardless of FSM state, and tick SHALL be ignored in that cycle.
REQ-026 A load value with a non-BCD digit (>9), or a value greater than MAX_VALUE, SHALL instead load MAX_VALUE and pulse load_err for one cycle.
REQ-027 A set SHALL NOT pulse cout or bout and SHALL NOT change the FSM state.
REQ-028 Priority SHALL be: reset > set > stop > start_resume > tick.
REQ-029 A change of down while counting SHALL take effect on the next qualifying tick, with no glitch pulse on cout or bout.
REQ-030 For MAX_VALUE < 10 the tens digit SHALL stay 0 throughout.
REQ-031 Neither output digit SHALL ever hold a non-BCD code or a value above MAX_VALUE.

Reset
REQ-032 While reset=1 at an edge, tens=0, ones=0, cout=0, bout=0 and load_err=0 SHALL result.
REQ-033 While reset=1 at an edge, running SHALL take the value RUN_ON_RESET.
REQ-034 Reset asserted mid-count SHALL discard any concurrent tick or set.
REQ-035 The first qualifying tick after reset is released SHALL count from 00.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (STOPPED=0, RUNNING=1), the BCD digit width (4), and the constants BCD_ZERO and BCD_NINE.
REQ-037 One sub-module, bcd_digit, SHALL be used for each digit.
REQ-038 bcd_digit SHALL provide a 4-bit register with synchronous load, an enable, up/down control, and a parametrised top value.
REQ-039 bcd_digit SHALL drive a combinational terminal-count output and a combinational terminal-zero output.
REQ-040 The top level SHALL instantiate bcd_digit twice (ones, tens) and own the FSM, the MAX_VALUE wrap decode, load validation, and the cout/bout registers.

Verification
REQ-041 With MAX_VALUE=59, reset then start_resume, then 60 ticks -> count reaches 59 after 59 ticks, the 60th tick gives 00, and cout is high for exactly one cycle.
REQ-042 With MAX_VALUE=23 and down=1, set 00 then tick -> count becomes 23 and bout pulses once; a further tick gives 22.
REQ-043 In RUNNING at 37, assert stop with a tick in the same cycle -> count holds 37 and running=0; start_resume followed by a tick -> 38.
REQ-044 set with init 7/2 (72) at MAX_VALUE=59 -> count loads 59 and load_err pulses; init 3/A -> count loads 59 and load_err pulses; init 4/5 -> count loads 45 with no load_err.
REQ-045 Assert reset in the same cycle as set and tick at count 58 -> count becomes 00, running=RUN_ON_RESET, and cout, bout and load_err all stay 0.
REQ-046 Chain two instances (sec MAX 59, min MAX 59) with the seconds cout driving the minutes tick, starting from 59:59 -> after one tick both fields read 00 and the minutes cout pulses one cycle later than the seconds cout.
